// File: rtl/mem_line_requester.sv
// Core-side requester for the line-wide memory port: single-word loads, and stores done
// as read-modify-write of the whole line. One request in flight at a time.
//
// state | meaning
// IDLE  | ready for a core request
// RD    | line read outstanding
// GAP   | merge store bytes into the latched line, memory request dropped for a cycle
// WR    | merged line write outstanding
// RESP  | one-cycle response to the core
module mem_line_requester #(
    parameter int BITSIZE          = 32,
    parameter int N_WORDS_PER_ADDR = 4,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                                  clk,
    input  logic                                  reset_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic                                  req_we_i,
    input  logic [31:0]                           req_addr_i,
    input  logic [BITSIZE-1:0]                    req_wdata_i,
    input  logic [BITSIZE/8-1:0]                  req_be_i,
    output logic                                  rsp_valid_o,
    output logic [BITSIZE-1:0]                    rsp_rdata_o,
    output logic                                  rsp_err_o,
    output logic [31:0]                           mem_addr_o,
    output logic [BITSIZE*N_WORDS_PER_ADDR-1:0]   mem_data_o,
    input  logic [BITSIZE*N_WORDS_PER_ADDR-1:0]   mem_data_i,
    output logic                                  mem_store_o,
    output logic                                  mem_valid_o,
    input  logic                                  mem_valid_i
);

    localparam int LW   = BITSIZE * N_WORDS_PER_ADDR;
    localparam int NB   = BITSIZE / 8;
    localparam int WS_W = $clog2(N_WORDS_PER_ADDR);
    localparam int TW   = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, RD, GAP, WR, RESP} state_t;

    state_t             state;
    logic               we_q;
    logic [WS_W-1:0]    ws_q;
    logic [BITSIZE-1:0] wdata_q;
    logic [NB-1:0]      be_q;
    logic [LW-1:0]      line_q;
    logic [LW-1:0]      merged;
    logic [BITSIZE-1:0] rd_word;
    logic [TW-1:0]      tcnt;
    logic               tc_hit;

    assign mem_data_o = line_q;
    assign tc_hit     = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        rd_word = '0;
        for (int w = 0; w < N_WORDS_PER_ADDR; w++)
            if (ws_q == WS_W'(w))
                rd_word = mem_data_i[w*BITSIZE +: BITSIZE];
    end

    always_comb begin
        merged = line_q;
        for (int w = 0; w < N_WORDS_PER_ADDR; w++)
            for (int b = 0; b < NB; b++)
                if (ws_q == WS_W'(w) && be_q[b])
                    merged[w*BITSIZE + b*8 +: 8] = wdata_q[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_store_o <= 1'b0;
            mem_valid_o <= 1'b0;
            line_q      <= '0;
            we_q        <= 1'b0;
            ws_q        <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            tcnt        <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        ws_q        <= req_addr_i[WS_W+1:2];
                        wdata_q     <= req_wdata_i;
                        be_q        <= req_be_i;
                        mem_addr_o  <= {req_addr_i[31:WS_W+2], {(WS_W+2){1'b0}}};
                        mem_store_o <= 1'b0;
                        req_ready_o <= 1'b0;
                        if (req_addr_i[1:0] != 2'b00) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state       <= RD;
                            mem_valid_o <= 1'b1;
                            tcnt        <= '0;
                        end
                    end
                end
                RD: begin
                    if (mem_valid_i) begin
                        line_q      <= mem_data_i;
                        mem_valid_o <= 1'b0;
                        if (we_q) begin
                            state <= GAP;
                        end else begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_rdata_o <= rd_word;
                        end
                    end else if (tc_hit) begin
                        mem_valid_o <= 1'b0;
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    line_q      <= merged;
                    state       <= WR;
                    mem_valid_o <= 1'b1;
                    mem_store_o <= 1'b1;
                    tcnt        <= '0;
                end
                WR: begin
                    // Completion and timeout both end the write; only the error flag differs.
                    if (mem_valid_i || tc_hit) begin
                        mem_valid_o <= 1'b0;
                        mem_store_o <= 1'b0;
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= ~mem_valid_i;
                        rsp_rdata_o <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= '0;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    mem_valid_o <= 1'b0;
                    mem_store_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
